// File: rtl/light_gen_multi.sv
// light_gen_multi: NUM_CH independent light/tick channels (OFF/ON/PWM/ONESHOT) stepped by a shared prescaler.
// Latency: config visible on o_light the cycle after acceptance; o_tick is registered, one cycle after the event edge.
// Backpressure: o_cfg_ready is low only in reset and on the first edge after release; writes to ch >= NUM_CH are dropped.
module light_gen_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 25,
  parameter int PRESCALE = 1,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [1:0]        i_cfg_mode,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic [CNT_W-1:0]  i_cfg_duty,
  output logic [NUM_CH-1:0] o_light,
  output logic [NUM_CH-1:0] o_tick
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic              ready_q, ready_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              strobe;
  logic              cfg_acc;

  logic [1:0]        mode_q   [NUM_CH];
  logic [1:0]        mode_d   [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  logic [CNT_W-1:0]  duty_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W:0]    cnt_inc  [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Global prescaler, strobe generation and config handshake
  always_comb begin
    ready_d = 1'b1;
    cfg_acc = i_cfg_valid && ready_q;
    strobe  = i_en && (pre_q == PRE_LAST);
    pre_d   = pre_q;
    if (i_en) begin
      pre_d = strobe ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Per-channel increment and PWM wrap detect; period 0 behaves as period 1
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_inc[c] = {1'b0, cnt_q[c]} + (CNT_W+1)'(1);
      wrap[c]    = (period_q[c] == '0) ? 1'b1 : (cnt_q[c] == period_q[c] - CNT_W'(1));
    end
  end

  // Per-channel next state: a write to the channel wins over a step on the same edge
  always_comb begin
    tick_d = '0;
    done_d = done_q;
    for (int c = 0; c < NUM_CH; c++) begin
      mode_d[c]   = mode_q[c];
      period_d[c] = period_q[c];
      duty_d[c]   = duty_q[c];
      cnt_d[c]    = cnt_q[c];
      if (cfg_acc && (int'(i_cfg_ch) == c)) begin
        mode_d[c]   = i_cfg_mode;
        period_d[c] = i_cfg_period;
        duty_d[c]   = i_cfg_duty;
        cnt_d[c]    = '0;
        // A zero-length one-shot is finished before it starts: no light, no tick
        done_d[c]   = (i_cfg_mode == MODE_ONESHOT) && (i_cfg_duty == '0);
      end else if (strobe) begin
        case (mode_q[c])
          MODE_PWM: begin
            if (wrap[c]) begin
              cnt_d[c]  = '0;
              tick_d[c] = 1'b1;
            end else begin
              cnt_d[c] = cnt_inc[c][CNT_W-1:0];
            end
          end
          MODE_ONESHOT: begin
            if (!done_q[c]) begin
              if (cnt_inc[c] >= {1'b0, duty_q[c]}) begin
                done_d[c] = 1'b1;
                tick_d[c] = 1'b1;
              end else begin
                cnt_d[c] = cnt_inc[c][CNT_W-1:0];
              end
            end
          end
          default: cnt_d[c] = '0;
        endcase
      end
    end
  end

  // Light level decoded purely from registered state
  always_comb begin
    o_light = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode_q[c])
        MODE_OFF:     o_light[c] = 1'b0;
        MODE_ON:      o_light[c] = 1'b1;
        MODE_PWM:     o_light[c] = (cnt_q[c] < duty_q[c]);
        default:      o_light[c] = (cnt_q[c] < duty_q[c]) && !done_q[c];
      endcase
    end
  end

  assign o_tick      = tick_q;
  assign o_cfg_ready = ready_q;

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_q <= 1'b0;
      pre_q   <= '0;
      done_q  <= '0;
      tick_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c]   <= MODE_OFF;
        period_q[c] <= '0;
        duty_q[c]   <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      ready_q <= ready_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_q[c]   <= mode_d[c];
        period_q[c] <= period_d[c];
        duty_q[c]   <= duty_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

endmodule

// File: tb/tb_light_gen_multi.sv
// Bench for light_gen_multi: one 4-channel instance at PRESCALE=1 and one 3-channel instance at PRESCALE=2,
// both driven by the same inputs. Expectations come from a table, hand sequences and a steps-since-load model.
module tb_light_gen_multi;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, en, valid;
  logic [1:0]    ch, mode;
  logic [CW-1:0] period, duty;
  logic          rdy1, rdy2;
  logic [3:0]    light1, tick1;
  logic [2:0]    light2, tick2;

  int checks = 0;
  int failures = 0;

  light_gen_multi #(.NUM_CH(4), .CNT_W(CW), .PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_valid(valid), .o_cfg_ready(rdy1),
    .i_cfg_ch(ch), .i_cfg_mode(mode), .i_cfg_period(period), .i_cfg_duty(duty),
    .o_light(light1), .o_tick(tick1));

  light_gen_multi #(.NUM_CH(3), .CNT_W(CW), .PRESCALE(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_valid(valid), .o_cfg_ready(rdy2),
    .i_cfg_ch(ch), .i_cfg_mode(mode), .i_cfg_period(period), .i_cfg_duty(duty),
    .o_light(light2), .o_tick(tick2));

  always #5 clk = ~clk;

  // Reference model: each channel counts strobes since its last write (s);
  // light and tick follow from s by modular arithmetic.
  int     NCH [2] = '{4, 3};
  int     PS  [2] = '{1, 2};
  int     m_mode [2][4];
  int     m_per  [2][4];
  int     m_duty [2][4];
  longint m_s    [2][4];
  bit     m_tick [2][4];
  int     m_encnt[2];
  bit     m_rdy;

  function automatic bit exp_light(int d, int c);
    longint pe;
    pe = (m_per[d][c] == 0) ? 1 : m_per[d][c];
    case (m_mode[d][c])
      0: return 1'b0;
      1: return 1'b1;
      2: return (m_s[d][c] % pe) < m_duty[d][c];
      default: return m_s[d][c] < m_duty[d][c];
    endcase
  endfunction

  task automatic model_reset();
    m_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_encnt[d] = 0;
      for (int c = 0; c < 4; c++) begin
        m_mode[d][c] = 0; m_per[d][c] = 0; m_duty[d][c] = 0;
        m_s[d][c] = 0; m_tick[d][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    bit acc, stb;
    longint pe;
    acc = valid && m_rdy;
    for (int d = 0; d < 2; d++) begin
      stb = 1'b0;
      if (en) begin
        m_encnt[d] = m_encnt[d] + 1;
        stb = (m_encnt[d] % PS[d]) == 0;
      end
      for (int c = 0; c < NCH[d]; c++) begin
        m_tick[d][c] = 1'b0;
        if (acc && int'(ch) == c) begin
          m_mode[d][c] = int'(mode); m_per[d][c] = int'(period);
          m_duty[d][c] = int'(duty); m_s[d][c] = 0;
        end else if (stb) begin
          pe = (m_per[d][c] == 0) ? 1 : m_per[d][c];
          if (m_mode[d][c] == 2) begin
            m_s[d][c] = m_s[d][c] + 1;
            if (m_s[d][c] % pe == 0) m_tick[d][c] = 1'b1;
          end else if (m_mode[d][c] == 3 && m_s[d][c] < m_duty[d][c]) begin
            m_s[d][c] = m_s[d][c] + 1;
            if (m_s[d][c] == m_duty[d][c]) m_tick[d][c] = 1'b1;
          end
        end
      end
    end
    m_rdy = 1'b1;
  endtask

  task automatic check(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] el1, et1;
    logic [2:0] el2, et2;
    for (int c = 0; c < 4; c++) begin el1[c] = exp_light(0, c); et1[c] = m_tick[0][c]; end
    for (int c = 0; c < 3; c++) begin el2[c] = exp_light(1, c); et2[c] = m_tick[1][c]; end
    check("model_light_p1", light1, el1);
    check("model_tick_p1",  tick1,  et1);
    check("model_ready_p1", rdy1,   m_rdy);
    check("model_light_p2", light2, el2);
    check("model_tick_p2",  tick2,  et2);
    check("model_ready_p2", rdy2,   m_rdy);
  endtask

  // One clock: inputs already set, model follows the edge, outputs sampled 1 time unit later
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic write(input logic [1:0] c, input logic [1:0] m, input int p, input int d);
    valid = 1'b1; ch = c; mode = m; period = CW'(p); duty = CW'(d);
    cycle();
    valid = 1'b0;
  endtask

  typedef struct {
    bit            v;
    bit            e;
    logic [1:0]    m;
    logic [CW-1:0] p;
    logic [CW-1:0] d;
    bit            l0;
    bit            t0;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit v, bit e, int m, int p, int d, bit l0, bit t0);
    vec_t r;
    r.v = v; r.e = e; r.m = 2'(m); r.p = CW'(p); r.d = CW'(d); r.l0 = l0; r.t0 = t0;
    return r;
  endfunction

  initial begin
    int n_hi, n_tk, n_hi1, n_tk1, n_chg;
    bit l0_frozen;

    // ch0 PWM period 4 duty 1, a freeze, and a re-write on a strobe edge
    tbl[0]  = mk(1, 1, 2, 4, 1, 1, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 1, 1);
    tbl[11] = mk(1, 1, 2, 4, 2, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; en = 1'b0; valid = 1'b0; ch = '0; mode = '0; period = '0; duty = '0;
    #12;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    cycle();
    check("ready_after_release", rdy1, 1);
    en = 1'b1;

    // Table-driven sequence on dut1 channel 0
    for (int i = 0; i < 14; i++) begin
      valid = tbl[i].v; en = tbl[i].e; ch = 2'd0;
      mode = tbl[i].m; period = tbl[i].p; duty = tbl[i].d;
      cycle();
      check("tbl_light0", light1[0], tbl[i].l0);
      check("tbl_tick0",  tick1[0],  tbl[i].t0);
    end
    valid = 1'b0; en = 1'b1;

    // Period 0 ticks every step; duty beyond period keeps light high
    write(2'd1, 2'd2, 0, 0);
    write(2'd2, 2'd2, 5, 7);
    n_tk = 0; n_tk1 = 0; n_hi = 0; n_hi1 = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tk1 += int'(tick1[1]); n_tk += int'(tick1[2]);
      n_hi1 += int'(light1[1]); n_hi += int'(light1[2]);
    end
    check("p0_ticks",     n_tk1, 10);
    check("p0_light_hi",  n_hi1, 0);
    check("duty7_ticks",  n_tk, 2);
    check("duty7_hi",     n_hi, 10);

    // One-shot duty 3 written on a dut2 strobe edge
    if (m_encnt[1] % 2 == 0) cycle();
    write(2'd2, 2'd3, 0, 3);
    n_hi = int'(light2[2]); n_tk = int'(tick2[2]);
    n_hi1 = int'(light1[2]); n_tk1 = int'(tick1[2]);
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_hi += int'(light2[2]); n_tk += int'(tick2[2]);
      n_hi1 += int'(light1[2]); n_tk1 += int'(tick1[2]);
    end
    check("oneshot_p2_hi",   n_hi, 6);
    check("oneshot_p2_tick", n_tk, 1);
    check("oneshot_p1_hi",   n_hi1, 3);
    check("oneshot_p1_tick", n_tk1, 1);

    // Zero-length one-shot
    write(2'd0, 2'd3, 0, 0);
    n_hi = int'(light1[0]); n_tk = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_hi += int'(light1[0]); n_tk += int'(tick1[0]);
    end
    check("oneshot0_hi",   n_hi, 0);
    check("oneshot0_tick", n_tk, 0);

    // Freeze: ch0 PWM, disable for 10 cycles, write ch1 ON meanwhile
    write(2'd0, 2'd2, 4, 1);
    cycle(); cycle();
    en = 1'b0;
    l0_frozen = exp_light(0, 0);
    write(2'd1, 2'd1, 0, 0);
    check("on_while_disabled", light1[1], 1);
    n_tk = 0; n_chg = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_tk += int'(tick1) + int'(tick2);
      n_chg += int'(light1[0] != l0_frozen);
    end
    check("disabled_ticks", n_tk, 0);
    check("disabled_light_changes", n_chg, 0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Channel index beyond dut2's range is ignored there
    write(2'd3, 2'd0, 0, 0);
    check("bad_ch_keeps_on", light2[1], 1);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      valid  = ($urandom % 4) == 0;
      ch     = 2'($urandom % 4);
      mode   = 2'($urandom % 4);
      period = CW'($urandom % 6);
      duty   = CW'($urandom % 8);
      en     = ($urandom % 8) != 0;
      cycle();
    end
    valid = 1'b0; en = 1'b1;

    // Reset in the middle of PWM activity
    write(2'd0, 2'd2, 1, 1);
    cycle();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_light", light1, 0);
    check("midrst_tick",  tick1,  0);
    check("midrst_ready", rdy1,   0);
    check_all();
    cycle();
    rst = 1'b0;
    cycle();
    check("rerelease_ready", rdy1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_reset_off", {light1, light2}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
